// File: rtl/led_pkg.sv
// Shared constants and width helpers for the LED PWM/blink datapath.
package led_pkg;

  localparam int DUTY_W = 8;
  localparam logic [DUTY_W-1:0] PWM_MAX = 8'hFF;
  localparam int LED_N_DEFAULT = 8;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

  // A divide-by-1 counter still needs a 1-bit register to stay legal.
  function automatic int cnt_width(input int div);
    return (clog2(div) < 1) ? 1 : clog2(div);
  endfunction

endpackage

// File: rtl/led_tick_div.sv
// Modulo-DIV up-counter; tick marks the advancing cycle on which it wraps.
module led_tick_div
  import led_pkg::*;
#(
  parameter int DIV = 2
) (
  input  logic HCLK,
  input  logic HRESET,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int W = cnt_width(DIV);
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    tick  = en & ~clr & (cnt_q == LAST);
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + W'(1);
    end
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/led_pwm_blinker.sv
// LED pad driver: global PWM dimming plus per-channel blinking, with register
// inputs shadowed so they only change on PWM period boundaries.
module led_pwm_blinker
  import led_pkg::*;
#(
  parameter int N_LED     = LED_N_DEFAULT,
  parameter int PRESC_DIV = 50,
  parameter int BLINK_DIV = 64
) (
  input  logic              HCLK,
  input  logic              HRESET,
  input  logic              enable,
  input  logic [N_LED-1:0]  led_in,
  input  logic [N_LED-1:0]  blink_mask,
  input  logic [DUTY_W-1:0] duty,
  output logic [N_LED-1:0]  led_out,
  output logic              period_tick,
  output logic              blink_phase
);

  logic              step;
  logic              blink_wrap;
  logic              pwm_on;

  logic [DUTY_W-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [DUTY_W-1:0] duty_q, duty_d;
  logic [N_LED-1:0]  led_q, led_d;
  logic [N_LED-1:0]  mask_q, mask_d;
  logic [N_LED-1:0]  led_out_q, led_out_d;
  logic              blink_phase_q, blink_phase_d;

  led_tick_div #(.DIV(PRESC_DIV)) u_presc (
    .HCLK   (HCLK),
    .HRESET (HRESET),
    .en     (enable),
    .clr    (~enable),
    .tick   (step)
  );

  led_tick_div #(.DIV(BLINK_DIV)) u_blink (
    .HCLK   (HCLK),
    .HRESET (HRESET),
    .en     (period_tick),
    .clr    (~enable),
    .tick   (blink_wrap)
  );

  assign period_tick = step & (pwm_cnt_q == PWM_MAX);

  always_comb begin
    pwm_cnt_d     = pwm_cnt_q;
    blink_phase_d = blink_phase_q;
    led_d         = led_q;
    mask_d        = mask_q;
    duty_d        = duty_q;
    pwm_on        = (duty_q == PWM_MAX) | (pwm_cnt_q < duty_q);

    if (!enable) begin
      pwm_cnt_d     = '0;
      blink_phase_d = 1'b0;
    end else begin
      if (step) begin
        pwm_cnt_d = (pwm_cnt_q == PWM_MAX) ? '0 : pwm_cnt_q + DUTY_W'(1);
      end
      if (blink_wrap) begin
        blink_phase_d = ~blink_phase_q;
      end
    end

    // Tracking inputs while disabled makes the first enabled period current.
    if (!enable || period_tick) begin
      led_d  = led_in;
      mask_d = blink_mask;
      duty_d = duty;
    end

    led_out_d = '0;
    if (enable) begin
      led_out_d = led_q & {N_LED{pwm_on}} & (~mask_q | {N_LED{blink_phase_q}});
    end
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      pwm_cnt_q     <= '0;
      duty_q        <= '0;
      led_q         <= '0;
      mask_q        <= '0;
      led_out_q     <= '0;
      blink_phase_q <= 1'b0;
    end else begin
      pwm_cnt_q     <= pwm_cnt_d;
      duty_q        <= duty_d;
      led_q         <= led_d;
      mask_q        <= mask_d;
      led_out_q     <= led_out_d;
      blink_phase_q <= blink_phase_d;
    end
  end

  assign led_out     = led_out_q;
  assign blink_phase = blink_phase_q;

endmodule

// File: tb/tb_led_pwm_blinker.sv
// Directed and randomized bench for led_pwm_blinker against a cycle-count model.
module tb_led_pwm_blinker;

  localparam int P   = 2;
  localparam int B   = 2;
  localparam int N   = 8;
  localparam int PER = 256 * P;

  logic         HCLK = 1'b0;
  logic         HRESET;
  logic         enable;
  logic [N-1:0] led_in;
  logic [N-1:0] blink_mask;
  logic [7:0]   duty;
  logic [N-1:0] led_out;
  logic         period_tick;
  logic         blink_phase;

  int vectors    = 0;
  int miscompares = 0;

  // Model state: t = enabled clock edges since the last enable/reset.
  int         t = 0;
  logic [7:0] led_a = '0;
  logic [7:0] mask_a = '0;
  logic [7:0] duty_a = '0;
  logic [7:0] exp_led = '0;
  logic       exp_tick;
  logic       exp_phase;

  led_pwm_blinker #(
    .N_LED     (N),
    .PRESC_DIV (P),
    .BLINK_DIV (B)
  ) dut (
    .HCLK        (HCLK),
    .HRESET      (HRESET),
    .enable      (enable),
    .led_in      (led_in),
    .blink_mask  (blink_mask),
    .duty        (duty),
    .led_out     (led_out),
    .period_tick (period_tick),
    .blink_phase (blink_phase)
  );

  always #5 HCLK = ~HCLK;

  initial begin
    #2ms;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv)
    else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h t=%0d", tag, obs, expv, t);
    end
  endtask

  task automatic step();
    int   pwm;
    logic on;
    logic ph;
    @(posedge HCLK);
    if (HRESET) begin
      t = 0; led_a = '0; mask_a = '0; duty_a = '0; exp_led = '0;
    end else begin
      pwm = (t / P) % 256;
      ph  = (((t / PER) / B) % 2) == 1;
      on  = (duty_a == 8'hFF) || (pwm < duty_a);
      exp_led = enable ? (led_a & {8{on}} & (~mask_a | {8{ph}})) : 8'h00;
      if (!enable || (t % PER) == PER - 1) begin
        led_a = led_in; mask_a = blink_mask; duty_a = duty;
      end
      t = enable ? t + 1 : 0;
    end
    #1;
    exp_phase = (((t / PER) / B) % 2) == 1;
    exp_tick  = enable && !HRESET && ((t % PER) == PER - 1);
    check("led_out", 32'(led_out), 32'(exp_led));
    check("period_tick", 32'(period_tick), 32'(exp_tick));
    check("blink_phase", 32'(blink_phase), 32'(exp_phase));
  endtask

  task automatic run_to_tick();
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (!period_tick && n < 2 * PER);
    check("tick_wait", 32'(period_tick), 32'd1);
  endtask

  task automatic pulse_reset();
    #2;
    HRESET = 1'b1;
    enable = 1'b0;
    #1;
    check("rst_async_led", 32'(led_out), 32'd0);
    check("rst_async_tick", 32'(period_tick), 32'd0);
    check("rst_async_phase", 32'(blink_phase), 32'd0);
    step();
    step();
    HRESET = 1'b0;
    repeat (4) begin
      step();
      check("rst_hold_dark", 32'(led_out), 32'd0);
    end
  endtask

  initial begin
    int ones;
    int ticks;
    int cnt_a5;
    int cnt_a0;
    int len;
    HRESET = 1'b1; enable = 1'b0;
    led_in = '0; blink_mask = '0; duty = '0;
    repeat (3) step();
    HRESET = 1'b0;
    repeat (3) step();
    check("reset_led", 32'(led_out), 32'd0);

    // Half duty: 256 cycles lit, 256 dark, one tick per 512 cycles.
    led_in = 8'hFF; blink_mask = 8'h00; duty = 8'd128;
    step();
    enable = 1'b1;
    ones = 0; ticks = 0;
    for (int i = 0; i < 2 * PER; i++) begin
      step();
      if (i < PER && led_out == 8'hFF) ones++;
      if (period_tick) ticks++;
    end
    check("duty128_on_cycles", 32'(ones), 32'd256);
    check("duty128_ticks", 32'(ticks), 32'd2);

    repeat (100) step();
    check("lit_before_reset", 32'(led_out), 32'hFF);
    pulse_reset();

    // Duty extremes.
    enable = 1'b1; duty = 8'd0;
    run_to_tick();
    step();
    ones = 0;
    repeat (PER) begin step(); if (led_out != 8'h00) ones++; end
    check("duty0_lit_cycles", 32'(ones), 32'd0);
    duty = 8'hFF;
    run_to_tick();
    step();
    ones = 0;
    repeat (2 * PER) begin step(); if (led_out != 8'hFF) ones++; end
    check("duty255_gap_cycles", 32'(ones), 32'd0);

    // Blinking: upper nibble steady, lower nibble on alternate 2-period phases.
    led_in = 8'hA5; blink_mask = 8'h0F; duty = 8'hFF;
    run_to_tick();
    step();
    cnt_a5 = 0; cnt_a0 = 0;
    repeat (4 * PER) begin
      step();
      if (led_out == 8'hA5) cnt_a5++;
      if (led_out == 8'hA0) cnt_a0++;
    end
    check("blink_a5_cycles", 32'(cnt_a5), 32'd1024);
    check("blink_a0_cycles", 32'(cnt_a0), 32'd1024);

    // Mid-period duty change applies only from the next boundary.
    led_in = 8'hFF; blink_mask = 8'h00; duty = 8'd128;
    run_to_tick();
    step();
    ones = 0;
    repeat (100) begin step(); if (led_out == 8'hFF) ones++; end
    duty = 8'd32;
    repeat (PER - 100) begin step(); if (led_out == 8'hFF) ones++; end
    check("midchange_cur_on", 32'(ones), 32'd256);
    ones = 0;
    repeat (PER) begin step(); if (led_out == 8'hFF) ones++; end
    check("midchange_next_on", 32'(ones), 32'd64);

    // Disable mid-period, change pattern, re-enable.
    repeat (50) step();
    enable = 1'b0; led_in = 8'h3C;
    repeat (10) begin
      step();
      check("disabled_dark", 32'(led_out), 32'd0);
    end
    enable = 1'b1;
    step();
    check("reenable_pattern", 32'(led_out), 32'h3C);
    repeat (PER) step();

    for (int seg = 0; seg < 25; seg++) begin
      led_in     = 8'($urandom);
      blink_mask = 8'($urandom);
      case ($urandom_range(0, 3))
        0:       duty = 8'd0;
        1:       duty = 8'hFF;
        default: duty = 8'($urandom);
      endcase
      enable = ($urandom_range(0, 5) != 0);
      if ($urandom_range(0, 9) == 0) begin
        pulse_reset();
        enable = 1'b1;
      end
      len = $urandom_range(1, 900);
      repeat (len) step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
